alba_control: RTL and testbench

Multicycle control unit for the albaCore 16-bit processor. It sequences the datapath through fetch, decode, execute, memory and write-back from the 4-bit `opcode` and the `zero`/`neg` ALU flags. It also runs the ready/acknowledge handshake with instruction/data memory and initialises the PC, which has no reset of its own. It sits beside `datapath` in the CPU top and drives every datapath select and enable.

---
 rtl/alba_pkg.sv | 45 ++++
 rtl/alba_control_if.sv | 34 +++
 rtl/alba_control.sv | 169 ++++++++++++++++
 tb/tb_alba_control.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alba_pkg.sv
// Shared encodings for the albaCore control unit: opcodes, ALU function selects and
// controller states. The ALU decodes alu_op from these same localparams.
package alba_pkg;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpNot  = 4'h4;
  localparam logic [3:0] OpShl  = 4'h5;
  localparam logic [3:0] OpShr  = 4'h6;
  localparam logic [3:0] OpLdi  = 4'h7;
  localparam logic [3:0] OpLd   = 4'h8;
  localparam logic [3:0] OpSt   = 4'h9;
  localparam logic [3:0] OpBr   = 4'hA;
  localparam logic [3:0] OpBz   = 4'hB;
  localparam logic [3:0] OpBn   = 4'hC;
  localparam logic [3:0] OpJal  = 4'hD;
  localparam logic [3:0] OpJr   = 4'hE;
  localparam logic [3:0] OpQuit = 4'hF;

  // Codes 0-7 reuse the matching opcode's function.
  localparam logic [3:0] AluAdd    = 4'h0;
  localparam logic [3:0] AluAddr   = 4'h8;
  localparam logic [3:0] AluInc    = 4'h9;
  localparam logic [3:0] AluBr     = 4'hA;
  localparam logic [3:0] AluTest   = 4'hB;
  localparam logic [3:0] AluPassPc = 4'hC;
  localparam logic [3:0] AluJmp    = 4'hD;
  localparam logic [3:0] AluPassA  = 4'hE;
  localparam logic [3:0] AluZero   = 4'hF;

  typedef enum logic [3:0] {
    StInit,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StBranch,
    StLink,
    StHalt
  } state_e;

endpackage

// File: rtl/alba_control_if.sv
// Control/handshake bundle between alba_control (master) and the datapath plus
// memory side (slave).
interface alba_control_if;
  logic [3:0] opcode;
  logic       zero;
  logic       neg;
  logic       mem_ack;
  logic       s_addr;
  logic       en_inst;
  logic       en_a;
  logic       en_b;
  logic       en_f;
  logic       en_mdr;
  logic       s_regfile_din;
  logic       we_regfile;
  logic       s_regfile_rw;
  logic       en_pc;
  logic [3:0] alu_op;
  logic       mem_re;
  logic       mem_we;
  logic       halted;

  modport master (
    input  opcode, zero, neg, mem_ack,
    output s_addr, en_inst, en_a, en_b, en_f, en_mdr, s_regfile_din, we_regfile,
           s_regfile_rw, en_pc, alu_op, mem_re, mem_we, halted
  );

  modport slave (
    output opcode, zero, neg, mem_ack,
    input  s_addr, en_inst, en_a, en_b, en_f, en_mdr, s_regfile_din, we_regfile,
           s_regfile_rw, en_pc, alu_op, mem_re, mem_we, halted
  );
endinterface

// File: rtl/alba_control.sv
// Multicycle control FSM for albaCore: fetch/decode/execute/memory/write-back sequencing
// and memory handshake. Define ALBA_CTRL_STEP_EN to gate each fetch on a `step` pulse.
module alba_control
  import alba_pkg::*;
(
  input logic clk,
  input logic rst,
`ifdef ALBA_CTRL_STEP_EN
  input logic step,
`endif
  alba_control_if.master bus
);

  state_e state_q, state_d;
  logic   cond_q, cond_d;
  logic   fetch_go;

`ifdef ALBA_CTRL_STEP_EN
  // Registered step grant keeps step off the combinational output path.
  logic go_q, go_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      go_q <= 1'b0;
    end else begin
      go_q <= go_d;
    end
  end

  assign fetch_go = go_q;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cond_d            = cond_q;
`ifdef ALBA_CTRL_STEP_EN
    go_d              = go_q;
`endif
    bus.s_addr        = 1'b0;
    bus.en_inst       = 1'b0;
    bus.en_a          = 1'b0;
    bus.en_b          = 1'b0;
    bus.en_f          = 1'b0;
    bus.en_mdr        = 1'b0;
    bus.s_regfile_din = 1'b0;
    bus.we_regfile    = 1'b0;
    bus.s_regfile_rw  = 1'b0;
    bus.en_pc         = 1'b0;
    bus.alu_op        = AluAdd;
    bus.mem_re        = 1'b0;
    bus.mem_we        = 1'b0;
    bus.halted        = 1'b0;

    unique case (state_q)
      StInit: begin
        // PC has no reset: load it with zero through the ALU.
        bus.alu_op = AluZero;
        bus.en_pc  = 1'b1;
        state_d    = StFetch;
      end
      StFetch: begin
        if (fetch_go) begin
          bus.mem_re = 1'b1;
          if (bus.mem_ack) begin
            bus.en_inst = 1'b1;
            state_d     = StDecode;
          end
        end
`ifdef ALBA_CTRL_STEP_EN
        go_d = fetch_go ? !bus.mem_ack : step;
`endif
      end
      StDecode: begin
        bus.en_a   = 1'b1;
        bus.en_b   = 1'b1;
        bus.alu_op = AluInc;
        bus.en_pc  = 1'b1;
        state_d    = (bus.opcode == OpQuit) ? StHalt : StExec;
      end
      StExec: begin
        unique case (bus.opcode)
          OpAdd, OpSub, OpAnd, OpOr, OpNot, OpShl, OpShr, OpLdi: begin
            bus.alu_op = bus.opcode;
            bus.en_f   = 1'b1;
            state_d    = StWb;
          end
          OpLd, OpSt: begin
            bus.alu_op = AluAddr;
            bus.en_f   = 1'b1;
            state_d    = StMem;
          end
          OpBr: begin
            bus.alu_op = AluBr;
            bus.en_pc  = 1'b1;
            state_d    = StFetch;
          end
          OpBz, OpBn: begin
            bus.alu_op = AluTest;
            cond_d     = (bus.opcode == OpBz) ? bus.zero : bus.neg;
            state_d    = StBranch;
          end
          OpJal: begin
            bus.alu_op = AluPassPc;
            bus.en_f   = 1'b1;
            state_d    = StLink;
          end
          OpJr: begin
            bus.alu_op = AluPassA;
            bus.en_pc  = 1'b1;
            state_d    = StFetch;
          end
          default: state_d = StFetch;  // QUIT never reaches EXEC
        endcase
      end
      StMem: begin
        bus.s_addr = 1'b1;
        if (bus.opcode == OpLd) begin
          bus.mem_re = 1'b1;
          if (bus.mem_ack) begin
            bus.en_mdr = 1'b1;
            state_d    = StWb;
          end
        end else begin
          bus.mem_we = 1'b1;
          if (bus.mem_ack) begin
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        bus.we_regfile    = 1'b1;
        bus.s_regfile_din = (bus.opcode == OpLd);
        state_d           = StFetch;
      end
      StBranch: begin
        if (cond_q) begin
          bus.alu_op = AluBr;
          bus.en_pc  = 1'b1;
        end
        state_d = StFetch;
      end
      StLink: begin
        // r15 <= return address while PC <= jump target in the same cycle.
        bus.we_regfile   = 1'b1;
        bus.s_regfile_rw = 1'b1;
        bus.alu_op       = AluJmp;
        bus.en_pc        = 1'b1;
        state_d          = StFetch;
      end
      StHalt: begin
        bus.halted = 1'b1;
      end
      default: state_d = StInit;
    endcase
  end

endmodule

// File: tb/tb_alba_control.sv
// Directed bench for alba_control: the driver queues the expected control vector for every
// cycle it drives; a negedge monitor pops and compares against the DUT outputs.
module tb_alba_control;
  import alba_pkg::*;

  localparam logic [16:0] MSaddr = 17'h1 << 16;
  localparam logic [16:0] MInst  = 17'h1 << 15;
  localparam logic [16:0] MA     = 17'h1 << 14;
  localparam logic [16:0] MB     = 17'h1 << 13;
  localparam logic [16:0] MF     = 17'h1 << 12;
  localparam logic [16:0] MMdr   = 17'h1 << 11;
  localparam logic [16:0] MDin   = 17'h1 << 10;
  localparam logic [16:0] MWe    = 17'h1 << 9;
  localparam logic [16:0] MRw    = 17'h1 << 8;
  localparam logic [16:0] MPc    = 17'h1 << 7;
  localparam logic [16:0] MRe    = 17'h1 << 6;
  localparam logic [16:0] MMwe   = 17'h1 << 5;
  localparam logic [16:0] MHalt  = 17'h1 << 4;

  localparam logic [16:0] EInit = MPc | 17'hF;
  localparam logic [16:0] EDec  = MA | MB | MPc | 17'h9;

  typedef struct {
    logic [16:0] e;
    string       nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [3:0] cur_op;
  logic       cur_z, cur_n, cur_ack;
  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;

  alba_control_if bus ();

  assign bus.opcode  = cur_op;
  assign bus.zero    = cur_z;
  assign bus.neg     = cur_n;
  assign bus.mem_ack = cur_ack;

  alba_control dut (
    .clk (clk),
    .rst (rst),
`ifdef ALBA_CTRL_STEP_EN
    .step(step),
`endif
    .bus (bus)
  );

  always #5 clk = ~clk;

  wire [16:0] act = {bus.s_addr, bus.en_inst, bus.en_a, bus.en_b, bus.en_f, bus.en_mdr,
                     bus.s_regfile_din, bus.we_regfile, bus.s_regfile_rw, bus.en_pc,
                     bus.mem_re, bus.mem_we, bus.halted, bus.alu_op};

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t it;
      it = sbq.pop_front();
      checks++;
      if (act !== it.e) begin
        errors++;
        $display("FAIL %s: got %05h required %05h at %0t", it.nm, act, it.e, $time);
      end
    end
  end

  task automatic cyc(input logic [3:0] op, input logic r, input logic ack, input logic z,
                     input logic n, input logic [16:0] e, input string nm);
    @(posedge clk);
    #1;
    cur_op  = op;
    rst     = r;
    cur_ack = ack;
    cur_z   = z;
    cur_n   = n;
    sbq.push_back('{e, nm});
  endtask

  task automatic c(input logic [3:0] op, input logic ack, input logic [16:0] e,
                   input string nm);
    cyc(op, 1'b0, ack, 1'b0, 1'b0, e, nm);
  endtask

  task automatic fetch(input logic [3:0] op, input int nwait, input string nm);
`ifdef ALBA_CTRL_STEP_EN
    c(op, 1'b0, 17'h0, {nm, "_step_idle"});
`endif
    for (int i = 0; i < nwait; i++) c(op, 1'b0, MRe, {nm, "_fetch_wait"});
    c(op, 1'b1, MRe | MInst, {nm, "_fetch_ack"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; step = 1'b1;
    cur_op = 4'h0; cur_z = 1'b0; cur_n = 1'b0; cur_ack = 1'b0;
    repeat (2) @(posedge clk);

    c(OpAdd, 1'b0, EInit, "init");
    fetch(OpAdd, 0, "add");
    c(OpAdd, 1'b0, EDec, "add_dec");
    c(OpAdd, 1'b0, MF | 17'h0, "add_exec");
    c(OpAdd, 1'b0, MWe, "add_wb");

    fetch(OpLd, 1, "ld");
    c(OpLd, 1'b0, EDec, "ld_dec");
    c(OpLd, 1'b0, MF | 17'h8, "ld_exec");
    for (int i = 0; i < 3; i++) c(OpLd, 1'b0, MSaddr | MRe, "ld_mem_wait");
    c(OpLd, 1'b1, MSaddr | MRe | MMdr, "ld_mem_ack");
    c(OpLd, 1'b0, MWe | MDin, "ld_wb");

    fetch(OpSt, 0, "st");
    c(OpSt, 1'b1, EDec, "st_dec_stray_ack");
    c(OpSt, 1'b0, MF | 17'h8, "st_exec");
    c(OpSt, 1'b1, MSaddr | MMwe, "st_mem");

    fetch(OpBz, 0, "bz1");
    c(OpBz, 1'b0, EDec, "bz1_dec");
    cyc(OpBz, 1'b0, 1'b0, 1'b1, 1'b0, 17'hB, "bz1_exec");
    cyc(OpBz, 1'b0, 1'b0, 1'b0, 1'b0, MPc | 17'hA, "bz1_taken");

    fetch(OpBz, 0, "bz0");
    c(OpBz, 1'b0, EDec, "bz0_dec");
    cyc(OpBz, 1'b0, 1'b0, 1'b0, 1'b1, 17'hB, "bz0_exec");
    cyc(OpBz, 1'b0, 1'b0, 1'b1, 1'b1, 17'h0, "bz0_not_taken");

    fetch(OpBn, 0, "bn");
    c(OpBn, 1'b0, EDec, "bn_dec");
    cyc(OpBn, 1'b0, 1'b0, 1'b0, 1'b1, 17'hB, "bn_exec");
    c(OpBn, 1'b0, MPc | 17'hA, "bn_taken");

    fetch(OpBr, 0, "br");
    c(OpBr, 1'b0, EDec, "br_dec");
    c(OpBr, 1'b0, MPc | 17'hA, "br_exec");

    fetch(OpJal, 0, "jal");
    c(OpJal, 1'b0, EDec, "jal_dec");
    c(OpJal, 1'b0, MF | 17'hC, "jal_exec");
    c(OpJal, 1'b0, MWe | MRw | MPc | 17'hD, "jal_link");

    fetch(OpJr, 0, "jr");
    c(OpJr, 1'b0, EDec, "jr_dec");
    c(OpJr, 1'b0, MPc | 17'hE, "jr_exec");

    fetch(OpLdi, 0, "ldi");
    c(OpLdi, 1'b0, EDec, "ldi_dec");
    c(OpLdi, 1'b0, MF | 17'h7, "ldi_exec");
    c(OpLdi, 1'b0, MWe, "ldi_wb");

    // Reset while a fetch request is pending, then a late ack.
`ifdef ALBA_CTRL_STEP_EN
    c(OpQuit, 1'b0, 17'h0, "rst_step_idle");
`endif
    cyc(OpQuit, 1'b1, 1'b0, 1'b0, 1'b0, MRe, "rst_fetch_req");
`ifdef ALBA_CTRL_STEP_EN
    step = 1'b0;
`endif
    c(OpQuit, 1'b1, EInit, "rst_late_ack");
`ifdef ALBA_CTRL_STEP_EN
    c(OpQuit, 1'b0, 17'h0, "step_hold");
    c(OpQuit, 1'b0, 17'h0, "step_hold");
    step = 1'b1;
`endif
    fetch(OpQuit, 0, "quit");
    c(OpQuit, 1'b0, EDec, "quit_dec");
    for (int i = 0; i < 20; i++) c(OpQuit, i[0], MHalt, "halt_hold");
    cyc(OpQuit, 1'b1, 1'b0, 1'b0, 1'b0, MHalt, "halt_rst");
    c(OpAdd, 1'b0, EInit, "init_after_halt");
    fetch(OpAdd, 1, "refetch");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (act !== EDec) begin
      errors++;
      $display("FAIL refetch_dec: got %05h required %05h at %0t", act, EDec, $time);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never compared", sbq.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL coverage: only %0d checks ran", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
